keyed_sec_pipe: RTL and testbench

//  Parametrised, pipelined single-error-correcting (SEC) decoder with a serially loaded XOR key.

---
 rtl/keyed_sec_pipe.sv | 175 +++++++++++++++++
 tb/tb_keyed_sec_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyed_sec_pipe.sv
// keyed_sec_pipe: two-stage SEC decoder unlocked by a serially loaded XOR key.
// Ports: clk, rst_n (async low); key_load_start/key_bit -> key_armed;
//   in_valid/in_ready/in_data/in_chk -> out_valid/out_ready/out_data,
//   out_corrected, out_uncorr; err_cnt = saturating count of corrected words.
module keyed_sec_pipe #(
  parameter int DATA_W = 32,
  parameter int CHK_W = 6,
  parameter logic [2*DATA_W+CHK_W-1:0] CORRECT_KEY = '0,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_load_start,
  input  logic                 key_bit,
  output logic                 key_armed,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [CHK_W-1:0]     in_chk,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_corrected,
  output logic                 out_uncorr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int KEY_W = 2*DATA_W+CHK_W;
  localparam int CNT_W = $clog2(KEY_W);

  generate
    if (DATA_W > 2**CHK_W - CHK_W - 1) begin : g_bad_width
      $error("keyed_sec_pipe: DATA_W too large for CHK_W");
    end
  endgenerate

  // Data columns: ascending CHK_W-bit values with at least two ones,
  // so none can alias a single check-bit error or a zero syndrome.
  function automatic logic [DATA_W-1:0][CHK_W-1:0] build_cols();
    logic [DATA_W-1:0][CHK_W-1:0] c;
    int n;
    c = '0;
    n = 0;
    for (int v = 3; v < 2**CHK_W; v++) begin
      if ($countones(v) >= 2 && n < DATA_W) begin
        c[n] = CHK_W'(v);
        n++;
      end
    end
    return c;
  endfunction

  localparam logic [DATA_W-1:0][CHK_W-1:0] COLS = build_cols();

  typedef enum logic [1:0] {LOCKED, LOAD, ARMED} state_t;

  state_t             state, state_nx;
  logic [KEY_W-1:0]   key_reg;
  logic [KEY_W-1:0]   mask;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_last;
  logic               flush;

  logic [DATA_W-1:0]  in_mask, out_mask;
  logic [CHK_W-1:0]   chk_mask;

  logic               s1_v, s2_v, s2_adv, in_fire;
  logic [DATA_W-1:0]  s1_data;
  logic [CHK_W-1:0]   s1_syn;
  logic [DATA_W-1:0]  m_in;
  logic [CHK_W-1:0]   syn;
  logic [DATA_W-1:0]  fix;
  logic               dec_corr, dec_unc;

  assign mask     = key_reg ^ CORRECT_KEY;
  assign in_mask  = mask[DATA_W-1:0];
  assign chk_mask = mask[DATA_W +: CHK_W];
  assign out_mask = mask[DATA_W+CHK_W +: DATA_W];

  assign cnt_last = (cnt == CNT_W'(KEY_W-1));

  always_comb begin
    state_nx = state;
    unique case (state)
      LOCKED:  if (key_load_start) state_nx = LOAD;
      LOAD:    if (cnt_last) state_nx = ARMED;
      ARMED:   if (key_load_start) state_nx = LOAD;
      default: state_nx = LOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOCKED;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg <= '0;
      cnt     <= '0;
    end else if (state == LOAD) begin
      key_reg[cnt] <= key_bit;
      cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign key_armed = (state == ARMED);
  // A reload drops everything in flight so no word mixes two keys.
  assign flush     = key_armed & key_load_start;
  assign s2_adv    = !s2_v | out_ready;
  assign in_ready  = key_armed & (!s1_v | s2_adv);
  assign in_fire   = in_valid & in_ready;

  always_comb begin
    m_in = in_data ^ in_mask;
    syn  = in_chk ^ chk_mask;
    for (int i = 0; i < DATA_W; i++) begin
      if (m_in[i]) syn = syn ^ COLS[i];
    end
  end

  always_comb begin
    fix = '0;
    for (int i = 0; i < DATA_W; i++) begin
      fix[i] = (s1_syn == COLS[i]);
    end
  end

  assign dec_corr = (|fix) | $onehot(s1_syn);
  assign dec_unc  = (s1_syn != '0) & !dec_corr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v          <= 1'b0;
      s2_v          <= 1'b0;
      s1_data       <= '0;
      s1_syn        <= '0;
      out_data      <= '0;
      out_corrected <= 1'b0;
      out_uncorr    <= 1'b0;
    end else begin
      if (flush) begin
        s1_v <= 1'b0;
        s2_v <= 1'b0;
      end else begin
        if (in_fire)     s1_v <= 1'b1;
        else if (s2_adv) s1_v <= 1'b0;
        if (s2_adv)      s2_v <= s1_v;
      end
      if (in_fire) begin
        s1_data <= m_in;
        s1_syn  <= syn;
      end
      if (s2_adv && s1_v) begin
        out_data      <= (s1_data ^ fix) ^ out_mask;
        out_corrected <= dec_corr;
        out_uncorr    <= dec_unc;
      end
    end
  end

  assign out_valid = s2_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (s2_v && out_ready && out_corrected
                 && err_cnt != '1) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_keyed_sec_pipe.sv
// tb_keyed_sec_pipe: directed bench with scoreboard for keyed_sec_pipe.
// A second instance with a 1-bit counter shares the stimulus.
module tb_keyed_sec_pipe;

  localparam int DW = 32;
  localparam int CW = 6;
  localparam int KW = 2*DW+CW;
  localparam logic [KW-1:0] CK = 70'h15A5C3E91B7D0F61E2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_load_start = 1'b0;
  logic key_bit = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_chk = '0;

  logic key_armed, in_ready, out_valid;
  logic out_corrected, out_uncorr;
  logic [DW-1:0] out_data;
  logic [15:0] err_cnt;

  logic s_key_armed, s_in_ready, s_out_valid;
  logic s_out_corrected, s_out_uncorr;
  logic [DW-1:0] s_out_data;
  logic [0:0] s_err_cnt;

  keyed_sec_pipe #(
    .DATA_W(DW), .CHK_W(CW), .CORRECT_KEY(CK), .ERR_CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_load_start(key_load_start), .key_bit(key_bit),
    .key_armed(key_armed),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_chk(in_chk),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_corrected(out_corrected),
    .out_uncorr(out_uncorr), .err_cnt(err_cnt)
  );

  keyed_sec_pipe #(
    .DATA_W(DW), .CHK_W(CW), .CORRECT_KEY(CK), .ERR_CNT_W(1)
  ) u_sat (
    .clk(clk), .rst_n(rst_n),
    .key_load_start(key_load_start), .key_bit(key_bit),
    .key_armed(s_key_armed),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_chk(in_chk),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_corrected(s_out_corrected),
    .out_uncorr(s_out_uncorr), .err_cnt(s_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          corr;
    logic          unc;
    logic [DW-1:0] data;
  } res_t;

  res_t q[$];
  logic [KW-1:0] eff = '0;
  int n_assert = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  int n_out = 0;
  bit exp_armed = 1'b0;
  bit fired = 1'b0;
  bit prev_stall = 1'b0;
  res_t prev_out;

  function automatic logic [CW-1:0] col(input int idx);
    logic [CW-1:0] r;
    int n;
    r = '0;
    n = 0;
    for (int v = 1; v < (1 << CW); v++) begin
      if ($countones(v) >= 2) begin
        if (n == idx) r = CW'(v);
        n++;
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < DW; i++) if (d[i]) s ^= col(i);
    return s;
  endfunction

  function automatic res_t model(input logic [DW-1:0] d,
                                 input logic [CW-1:0] c);
    logic [DW-1:0] m;
    logic [CW-1:0] s;
    res_t r;
    m = d ^ eff[DW-1:0];
    s = enc(m) ^ c ^ eff[DW +: CW];
    r.data = m;
    r.corr = 1'b0;
    r.unc  = 1'b0;
    if (s != '0) begin
      r.unc = 1'b1;
      for (int i = 0; i < DW; i++) begin
        if (s == col(i)) begin
          r.data[i] = ~r.data[i];
          r.corr = 1'b1;
          r.unc  = 1'b0;
        end
      end
      if ($onehot(s)) begin
        r.corr = 1'b1;
        r.unc  = 1'b0;
      end
    end
    r.data = r.data ^ eff[DW+CW +: DW];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs driven; samples, then
  // advances one rising edge and returns at the next falling edge.
  task automatic tick();
    res_t e;
    bit flush;
    #1;
    chk("key_armed", key_armed, exp_armed);
    chk("in_ready", in_ready,
        exp_armed && (q.size() < 2 || out_ready));
    chk("err_cnt", err_cnt, exp_cnt);
    chk("sat_cnt", s_err_cnt, exp_cnt > 0);
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_word", {out_corrected, out_uncorr, out_data},
          prev_out);
    end
    fired = in_valid && in_ready;
    flush = key_load_start && exp_armed;
    if (out_valid && out_ready) begin
      chk("q_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_word", {out_corrected, out_uncorr, out_data}, e);
        if (e.corr) exp_cnt++;
        n_out++;
      end
    end
    if (fired) q.push_back(model(in_data, in_chk));
    prev_stall = out_valid && !out_ready && !flush;
    prev_out = {out_corrected, out_uncorr, out_data};
    @(posedge clk);
    if (flush) q.delete();
    @(negedge clk);
  endtask

  task automatic load_bits(input logic [KW-1:0] k);
    for (int i = 0; i < KW; i++) begin
      key_bit = k[i];
      tick();
    end
    exp_armed = 1'b1;
    eff = k ^ CK;
  endtask

  task automatic load_key(input logic [KW-1:0] k);
    key_load_start = 1'b1;
    tick();
    key_load_start = 1'b0;
    exp_armed = 1'b0;
    load_bits(k);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = 1'b1;
    in_data = d;
    in_chk = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("drained", q.size(), 0);
  endtask

  logic [DW-1:0] wd [8];
  logic [CW-1:0] wc [8];
  int sent;

  initial begin
    #1;
    chk("rst_armed", key_armed, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_corrected, out_uncorr}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // clean word through the correct key, latency check
    load_key(CK);
    out_ready = 1'b1;
    send(32'hDEADBEEF, enc(32'hDEADBEEF));
    #1 chk("lat_one_edge", out_valid, 0);
    tick();
    #1;
    chk("lat_two_edges", out_valid, 1);
    chk("t1_data", out_data, 32'hDEADBEEF);
    chk("t1_flags", {out_corrected, out_uncorr}, 0);
    drain();
    chk("t1_err_cnt", err_cnt, 0);

    // single, double, check-bit and uncorrectable errors
    send(32'h0000_0020, enc(32'h0));
    send(32'h0000_0060, enc(32'h0));
    send(32'h0000_0003, enc(32'h0));
    send(32'h0, 6'h04);
    send(32'h0, 6'h27);
    drain();
    chk("t2_err_cnt", err_cnt, 4);
    chk("t2_sat_cnt", s_err_cnt, 1);

    // wrong in_mask bit0, then wrong out_mask bit0
    load_key(CK ^ KW'(1));
    send(32'h0, 6'h00);
    send(32'h0, 6'h00);
    drain();
    load_key(CK ^ (KW'(1) << (DW+CW)));
    out_ready = 1'b1;
    send(32'h0, 6'h00);
    tick();
    #1 chk("t3_outmask", out_data, 32'h1);
    drain();

    // 8-word stream with backpressure on cycles 3..5
    load_key(CK);
    for (int k = 0; k < 8; k++) begin
      wd[k] = $urandom;
      wc[k] = enc(wd[k]);
      if (k % 3 == 1) wd[k][k] = ~wd[k][k];
    end
    sent = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid = (sent < 8);
      if (sent < 8) begin
        in_data = wd[sent];
        in_chk = wc[sent];
      end
      tick();
      if (fired) sent++;
    end
    in_valid = 1'b0;
    chk("t4_sent", sent, 8);
    drain();
    chk("t4_delivered", n_out, 8);

    // reload with two words in flight
    out_ready = 1'b0;
    send(32'h1234_5678, enc(32'h1234_5678));
    send(32'h9ABC_DEF0, enc(32'h9ABC_DEF0));
    key_load_start = 1'b1;
    tick();
    key_load_start = 1'b0;
    exp_armed = 1'b0;
    #1;
    chk("t5_flush_valid", out_valid, 0);
    chk("t5_flush_ready", in_ready, 0);
    load_bits(CK);
    send(32'hCAFE_F00D, enc(32'hCAFE_F00D));
    drain();

    // reset in the middle of a key load
    key_load_start = 1'b1;
    tick();
    key_load_start = 1'b0;
    exp_armed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key_bit = CK[i];
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("t5_rst_armed", key_armed, 0);
    chk("t5_rst_ready", in_ready, 0);
    chk("t5_rst_cnt", err_cnt, 0);
    exp_cnt = 0;
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    // saturation of the 1-bit counter
    load_key(CK);
    send(32'h1, 6'h00);
    send(32'h1, 6'h00);
    drain();
    chk("t6_err_cnt", err_cnt, 2);
    chk("t6_sat_cnt", s_err_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
